// File: rtl/isl_rec_arbiter.sv
// isl_rec_arbiter: two-requester round-robin arbiter that time-shares one gesture recognizer.
// Optional feature: define ISL_CODE_FILTER_EN to drop a repeated code from the same owner
// (it is accepted, but nothing is issued and no result is produced).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/reqN_code/ready   requester handshakes (N = 0, 1)
//   rec_rst, rec_code, rec_sai   shared recognizer reset, code and result
//   res_valid/res_id/res_sai     result to the consumer, held until res_ready
//   busy                         high whenever a transaction is in flight
module isl_rec_arbiter #(
    parameter logic [7:0] IDLE_CODE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_code,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_code,
    output logic       req1_ready,
    output logic       rec_rst,
    output logic [7:0] rec_code,
    input  logic [3:0] rec_sai,
    output logic       res_valid,
    output logic       res_id,
    output logic [3:0] res_sai,
    input  logic       res_ready,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, FLUSH, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic       prio, owner, last_owner, has_owner;
    logic [7:0] code_q, grant_code;
    logic       grant1, accept, need_flush, skip;

    always_comb begin
        grant1     = req1_valid & (~req0_valid | prio);
        grant_code = grant1 ? req1_code : req0_code;
        accept     = (state == IDLE) & ~rst & (req0_valid | req1_valid);
        req0_ready = accept & ~grant1;
        req1_ready = accept & grant1;
        // A different requester may have left the recognizer mid-gesture, so it must be cleared.
        need_flush = ~has_owner | (grant1 != last_owner);
`ifdef ISL_CODE_FILTER_EN
        // rec_code always holds last_owner's most recent issued code.
        skip       = has_owner & (grant1 == last_owner) & (grant_code == rec_code);
`else
        skip       = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (accept & ~skip) ? (need_flush ? FLUSH : ISSUE) : IDLE;
            FLUSH:   state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = RESP;
            RESP:    state_nx = res_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = state != IDLE;
    assign res_valid = state == RESP;
    assign rec_rst   = rst | (state == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            has_owner  <= 1'b0;
            code_q     <= 8'h00;
            rec_code   <= IDLE_CODE;
            res_id     <= 1'b0;
            res_sai    <= 4'b0000;
        end else begin
            state <= state_nx;
            if (accept) begin
                prio   <= ~grant1;
                owner  <= grant1;
                code_q <= grant_code;
            end
            // Without a flush the code goes straight from the requester on the accepting edge.
            if (state_nx == ISSUE)
                rec_code <= (state == IDLE) ? grant_code : code_q;
            if (state == WAIT) begin
                res_sai    <= rec_sai;
                res_id     <= owner;
                last_owner <= owner;
                has_owner  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_isl_rec_arbiter.sv
// tb_isl_rec_arbiter: directed and random checks of isl_rec_arbiter against a transaction-timeline model.
module tb_isl_rec_arbiter;
    logic       clk = 1'b0;
    logic       rst, req0_valid, req1_valid, res_ready;
    logic [7:0] req0_code, req1_code, rec_code;
    logic       req0_ready, req1_ready, rec_rst, res_valid, res_id, busy;
    logic [3:0] rec_sai, res_sai;

    isl_rec_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
        .rec_rst(rec_rst), .rec_code(rec_code), .rec_sai(rec_sai),
        .res_valid(res_valid), .res_id(res_id), .res_sai(res_sai),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, cyc = 0;
    // Model: a transaction is described by the cycle it was accepted in and the cycles
    // where its flush, code issue and result are due.
    bit         act = 0, m_prio = 0, m_has = 0, m_last = 0, m_own = 0, m_res_id = 0;
    int         t_flush = -1, t_code = 0, t_resp = 0;
    logic [7:0] m_code = 8'h00, m_pend = 8'h00;
    logic [3:0] m_res_sai = 4'h0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step(input bit r, input bit v0, input bit v1, input logic [7:0] c0,
                        input logic [7:0] c1, input logic [3:0] sai, input bit rr);
        bit g1, gv, resp, fl, filt, own;
        logic [7:0] code;
        @(negedge clk);
        rst = r; req0_valid = v0; req1_valid = v1; req0_code = c0; req1_code = c1;
        rec_sai = sai; res_ready = rr;
        #1;
        resp = act && cyc >= t_resp;
        g1   = v1 && (!v0 || m_prio);
        gv   = (v0 || v1) && !act && !r;
        chk("req0_ready", {7'd0, req0_ready}, {7'd0, gv && !g1});
        chk("req1_ready", {7'd0, req1_ready}, {7'd0, gv && g1});
        chk("rec_rst",    {7'd0, rec_rst},    {7'd0, r || (act && cyc == t_flush)});
        chk("busy",       {7'd0, busy},       {7'd0, act});
        chk("res_valid",  {7'd0, res_valid},  {7'd0, resp});
        chk("res_id",     {7'd0, res_id},     {7'd0, m_res_id});
        chk("res_sai",    {4'd0, res_sai},    {4'd0, m_res_sai});
        chk("rec_code",   rec_code,           m_code);
        if (r) begin
            act = 0; m_prio = 0; m_has = 0; m_last = 0; m_code = 8'h00; m_res_id = 0; m_res_sai = 4'h0;
        end else if (gv) begin
            own    = g1;
            code   = g1 ? c1 : c0;
            m_prio = !g1;
            fl     = !m_has || own != m_last;
            filt   = 0;
`ifdef ISL_CODE_FILTER_EN
            filt   = m_has && own == m_last && code == m_code;
`endif
            if (!filt) begin
                act     = 1;
                m_own   = own;
                m_pend  = code;
                t_flush = fl ? cyc + 1 : -1;
                t_code  = cyc + (fl ? 2 : 1);
                t_resp  = cyc + (fl ? 4 : 3);
                if (!fl) m_code = code;
            end
        end else if (act) begin
            if (cyc + 1 == t_code) m_code = m_pend;
            if (cyc == t_resp - 1) begin
                m_res_sai = sai; m_res_id = m_own; m_last = m_own; m_has = 1;
            end
            if (resp && rr) act = 0;
        end
        cyc++;
    endtask

    task automatic quiet(input int n, input logic [3:0] sai, input bit rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00, sai, rr);
    endtask

    initial begin
        logic [7:0] c0, c1;
        // Reset state
        step(1, 0, 0, 8'h00, 8'h00, 4'h0, 0);
        step(1, 1, 1, 8'h11, 8'h22, 4'h0, 0);
        quiet(1, 4'h0, 0);
        chk("reset_rec_code", rec_code, 8'h00);
        // First code after reset: flush, result in N+4
        step(0, 1, 0, 8'h90, 8'h00, 4'h1, 1);
        quiet(1, 4'h1, 1);
        chk("first_flush", {7'd0, rec_rst}, 8'h01);
        quiet(1, 4'h1, 1);
        chk("first_code", rec_code, 8'h90);
        quiet(2, 4'h1, 1);
        chk("first_res_valid", {7'd0, res_valid}, 8'h01);
        chk("first_res_sai", {4'd0, res_sai}, 8'h01);
        quiet(1, 4'h0, 1);
        // Same owner: no flush, result in N+3
        step(0, 1, 0, 8'hA4, 8'h00, 4'h2, 1);
        quiet(1, 4'h2, 1);
        chk("same_no_flush", {7'd0, rec_rst}, 8'h00);
        quiet(2, 4'h2, 1);
        chk("same_res_valid", {7'd0, res_valid}, 8'h01);
        chk("same_res_sai", {4'd0, res_sai}, 8'h02);
        quiet(1, 4'h0, 1);
        // Repeated code from the same owner (filtered or issued depending on the build)
        step(0, 1, 0, 8'hA4, 8'h00, 4'h3, 1);
        quiet(5, 4'h3, 1);
        // Both valid after reset: req0 first, then req1 with a flush; result held 5 cycles
        step(1, 0, 0, 8'h00, 8'h00, 4'h0, 0);
        step(0, 1, 1, 8'h31, 8'h42, 4'h5, 0);
        quiet(3, 4'h5, 0);
        quiet(5, 4'h6, 0);
        chk("held_busy", {7'd0, busy}, 8'h01);
        step(0, 1, 1, 8'h31, 8'h42, 4'h6, 1);
        step(0, 1, 1, 8'h31, 8'h42, 4'h7, 0);
        quiet(4, 4'h7, 1);
        chk("second_owner_id", {7'd0, res_id}, 8'h01);
        quiet(1, 4'h0, 1);
        // Reset during WAIT discards the result
        step(0, 1, 0, 8'h55, 8'h00, 4'h9, 1);
        quiet(2, 4'h9, 1);
        step(1, 0, 0, 8'h00, 8'h00, 4'h9, 1);
        chk("after_rst_busy_pre", {7'd0, busy}, 8'h01);
        quiet(1, 4'h9, 1);
        chk("after_rst_rec_code", rec_code, 8'h00);
        quiet(3, 4'h9, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            c0 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (($urandom_range(0, 1) != 0) ? 8'h90 : 8'hA4);
            c1 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (($urandom_range(0, 1) != 0) ? 8'h90 : 8'hA4);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                 c0, c1, 4'($urandom), $urandom_range(0, 2) != 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
